// File: rtl/iiitb_gc_rx.sv
// Gray-code link receiver: synchronizes the pad bus, decodes it and classifies each change as a +/-1 step or an error.
// Optional modular position counter is enabled by defining IIITB_GC_RX_POS_EN.
module iiitb_gc_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             dir_up,
  output logic             step_err,
  output logic [7:0]       err_count,
  output logic             locked,
  output logic [15:0]      pos
);

  typedef enum logic {ACQUIRE, TRACK} state_e;

  state_e                              state_q, state_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]                    prev_q, prev_d;
  logic [WIDTH-1:0]                    bin_q, bin_d;
  logic                                valid_q, valid_d;
  logic                                dir_q, dir_d;
  logic                                err_q, err_d;
  logic [7:0]                          cnt_q, cnt_d;
  logic                                locked_q, locked_d;
  logic [WIDTH-1:0]                    cur, cur_bin, delta;

  assign cur = sync_q[SYNC_STAGES-1];

  always_comb begin
    cur_bin            = '0;
    cur_bin[WIDTH-1]   = cur[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++)
      cur_bin[WIDTH-1-i] = cur_bin[WIDTH-i] ^ cur[WIDTH-1-i];
  end

  // bin_q always holds the decode of prev_q, so it serves as the previous binary value
  assign delta = cur_bin - bin_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= ACQUIRE;
      prev_q   <= '0;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], gray_in};
      state_q  <= state_d;
      prev_q   <= prev_d;
      bin_q    <= bin_d;
      valid_q  <= valid_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACQUIRE: if (enable)  state_d = TRACK;
      TRACK:   if (!enable) state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase
  end

  always_comb begin
    prev_d   = prev_q;
    bin_d    = bin_q;
    valid_d  = 1'b0;
    dir_d    = dir_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    locked_d = (state_d == TRACK);
    if (enable) begin
      if (state_q == ACQUIRE) begin
        prev_d = cur;
        bin_d  = cur_bin;
      end else if (cur != prev_q) begin
        prev_d = cur;
        bin_d  = cur_bin;
        if (delta == WIDTH'(1)) begin
          valid_d = 1'b1;
          dir_d   = 1'b1;
        end else if (delta == '1) begin
          valid_d = 1'b1;
          dir_d   = 1'b0;
        end else begin
          err_d = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

`ifdef IIITB_GC_RX_POS_EN
  logic [15:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (valid_d) pos_d = dir_d ? pos_q + 16'd1 : pos_q - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) pos_q <= '0;
    else       pos_q <= pos_d;
  end

  assign pos = pos_q;
`else
  assign pos = '0;
`endif

  assign bin_out   = bin_q;
  assign valid     = valid_q;
  assign dir_up    = dir_q;
  assign step_err  = err_q;
  assign err_count = cnt_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_iiitb_gc_rx.sv
// Directed bench for iiitb_gc_rx: table of Gray steps checked three cycles after each pad change, plus hand sequences.
module tb_iiitb_gc_rx;

`ifdef IIITB_GC_RX_POS_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  gray_in, bin_out, err_count;
  logic        valid, dir_up, step_err, locked;
  logic [15:0] pos;

  int checks = 0;
  int failures = 0;

  iiitb_gc_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out), .valid(valid), .dir_up(dir_up), .step_err(step_err),
    .err_count(err_count), .locked(locked), .pos(pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  gray;
    logic [7:0]  bin;
    logic        v;
    logic        d;
    logic        e;
    logic [7:0]  ec;
    logic [15:0] p;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pexp(input logic [15:0] p);
    return POS_EN ? p : 16'h0000;
  endfunction

  initial begin
    int vcnt, ecnt;
    vec[0]  = '{8'h01, 8'h01, 1'b1, 1'b1, 1'b0, 8'd0, 16'd1};
    vec[1]  = '{8'h03, 8'h02, 1'b1, 1'b1, 1'b0, 8'd0, 16'd2};
    vec[2]  = '{8'h02, 8'h03, 1'b1, 1'b1, 1'b0, 8'd0, 16'd3};
    vec[3]  = '{8'h06, 8'h04, 1'b1, 1'b1, 1'b0, 8'd0, 16'd4};
    vec[4]  = '{8'h07, 8'h05, 1'b1, 1'b1, 1'b0, 8'd0, 16'd5};
    vec[5]  = '{8'h05, 8'h06, 1'b1, 1'b1, 1'b0, 8'd0, 16'd6};
    vec[6]  = '{8'h04, 8'h07, 1'b1, 1'b1, 1'b0, 8'd0, 16'd7};
    vec[7]  = '{8'h0C, 8'h08, 1'b1, 1'b1, 1'b0, 8'd0, 16'd8};
    vec[8]  = '{8'h0D, 8'h09, 1'b1, 1'b1, 1'b0, 8'd0, 16'd9};
    vec[9]  = '{8'h0F, 8'h0A, 1'b1, 1'b1, 1'b0, 8'd0, 16'd10};
    vec[10] = '{8'h81, 8'hFE, 1'b0, 1'b1, 1'b1, 8'd1, 16'd10};
    vec[11] = '{8'h80, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd1, 16'd11};
    vec[12] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1, 16'd12};
    vec[13] = '{8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd1, 16'd11};
    vec[14] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1, 16'd12};
    vec[15] = '{8'h07, 8'h05, 1'b0, 1'b1, 1'b1, 8'd2, 16'd12};
    vec[16] = '{8'h07, 8'h05, 1'b0, 1'b1, 1'b0, 8'd2, 16'd12};

    reset = 1'b1; enable = 1'b0; gray_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_bin", bin_out, 8'h00);
    chk("rst_locked", locked, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_err", step_err, 1'b0);
    chk("rst_cnt", err_count, 8'h00);
    chk("rst_dir", dir_up, 1'b0);
    chk("rst_pos", pos, 16'h0000);

    // acquire at 0 and hold
    reset = 1'b0; enable = 1'b1;
    vcnt = 0; ecnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vcnt += int'(valid); ecnt += int'(step_err);
    end
    chk("acq_locked", locked, 1'b1);
    chk("acq_bin", bin_out, 8'h00);
    chk("acq_valid_count", vcnt, 0);
    chk("acq_err_count", ecnt, 0);
    chk("acq_cnt", err_count, 8'h00);

    // one pad change per clock; outputs lag by three sampling points
    for (int i = 0; i < 17 + 3; i++) begin
      if (i >= 3) begin
        chk($sformatf("v%0d_bin", i-3), bin_out, vec[i-3].bin);
        chk($sformatf("v%0d_valid", i-3), valid, vec[i-3].v);
        chk($sformatf("v%0d_dir", i-3), dir_up, vec[i-3].d);
        chk($sformatf("v%0d_err", i-3), step_err, vec[i-3].e);
        chk($sformatf("v%0d_cnt", i-3), err_count, vec[i-3].ec);
        chk($sformatf("v%0d_locked", i-3), locked, 1'b1);
        chk($sformatf("v%0d_pos", i-3), pos, pexp(vec[i-3].p));
      end
      if (i < 17) gray_in = vec[i].gray;
      @(negedge clk);
    end

    // 260 illegal jumps, counter saturates
    vcnt = 0; ecnt = 0;
    for (int i = 0; i < 263; i++) begin
      vcnt += int'(valid); ecnt += int'(step_err);
      if (i < 260) gray_in = (i % 2 == 0) ? 8'h00 : 8'h07;
      @(negedge clk);
    end
    vcnt += int'(valid); ecnt += int'(step_err);
    chk("sat_err_pulses", ecnt, 260);
    chk("sat_valid_pulses", vcnt, 0);
    chk("sat_cnt", err_count, 8'hFF);
    chk("sat_bin", bin_out, 8'h05);
    chk("sat_locked", locked, 1'b1);

    // enable low drops lock, re-acquire without error
    gray_in = 8'h0F;
    repeat (4) @(negedge clk);
    chk("t5_bin", bin_out, 8'h0A);
    chk("t5_cnt", err_count, 8'hFF);
    enable = 1'b0;
    @(negedge clk);
    chk("t5_unlock", locked, 1'b0);
    chk("t5_hold_bin", bin_out, 8'h0A);
    gray_in = 8'h07;
    repeat (3) @(negedge clk);
    chk("t5_idle_bin", bin_out, 8'h0A);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_relock", locked, 1'b1);
    chk("t5_reacq_bin", bin_out, 8'h05);
    chk("t5_reacq_err", step_err, 1'b0);
    chk("t5_reacq_valid", valid, 1'b0);
    chk("t5_reacq_cnt", err_count, 8'hFF);
    @(negedge clk);
    chk("t5_quiet_err", step_err, 1'b0);

    // build err_count=3, bin 0x0A, then reset mid-operation
    gray_in = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_pre_bin", bin_out, 8'h00);
    gray_in = 8'h07; @(negedge clk);
    gray_in = 8'h00; @(negedge clk);
    gray_in = 8'h0F;
    repeat (3) @(negedge clk);
    chk("t6_cnt3", err_count, 8'd3);
    chk("t6_bin0a", bin_out, 8'h0A);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_bin", bin_out, 8'h00);
    chk("t6_rst_locked", locked, 1'b0);
    chk("t6_rst_cnt", err_count, 8'h00);
    chk("t6_rst_valid", valid, 1'b0);
    chk("t6_rst_err", step_err, 1'b0);
    chk("t6_rst_dir", dir_up, 1'b0);
    chk("t6_rst_pos", pos, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_relock", locked, 1'b1);
    chk("t6_relock_bin", bin_out, 8'h00);
    chk("t6_relock_err", step_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
